draw_cell_highlight: RTL and testbench

- Parametrised successor to the per-square highlight stages.
- One instance highlights any one cell of a ROWS×COLS board in the player's colour; this replaces one fixed-coordinate stage per square.
- Sits in the VGA pixel pipeline after the board/grid drawer and before the X/O marker stages.
- Selection is updated only at frame boundaries, so the display never tears.
- The highlight optionally blinks at a frame-counted rate.

---
 rtl/draw_cell_highlight.sv | 183 ++++++++++++++++++
 tb/tb_draw_cell_highlight.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cell_highlight.sv
// Highlights one selectable cell of a ROWS x COLS board in the player's colour, two-stage pixel pipeline.
// Optional blinking is built when CELL_BLINK_EN is defined; otherwise the highlight is steady.
module draw_cell_highlight #(
  parameter int          COLS         = 3,
  parameter int          ROWS         = 3,
  parameter int          X0           = 0,
  parameter int          Y0           = 11,
  parameter int          CELL_W       = 339,
  parameter int          CELL_H       = 248,
  parameter int          GAP          = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR_P0     = 12'h00f,
  parameter logic [11:0] COLOR_P1     = 12'hff0,
  localparam int         NCELL        = ROWS * COLS,
  localparam int         CW           = (NCELL > 1) ? $clog2(NCELL) : 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [10:0]   hcount_in,
  input  logic [10:0]   vcount_in,
  input  logic          hsync_in,
  input  logic          hblnk_in,
  input  logic          vsync_in,
  input  logic          vblnk_in,
  input  logic [11:0]   rgb_in,
  input  logic          start_en,
  input  logic          choice_en,
  input  logic          cell_valid,
  input  logic [CW-1:0] cell_sel,
  input  logic          player,
  output logic [10:0]   hcount_out,
  output logic [10:0]   vcount_out,
  output logic          hsync_out,
  output logic          hblnk_out,
  output logic          vsync_out,
  output logic          vblnk_out,
  output logic [11:0]   rgb_out
);

`ifdef CELL_BLINK_EN
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  localparam int FCW = $clog2(BLINK_FRAMES) + 1;
  logic [FCW-1:0] fcnt_q, fcnt_d;
`else
  typedef enum logic {IDLE, ON} state_t;
`endif

  state_t          state_q, state_d;
  logic            vsync_q;
  logic            boundary;
  logic            sel_ok, en_now;
  logic [CW-1:0]   sel_q;
  logic            player_q;
  logic [10:0]     x_lo_q, x_hi_q, y_lo_q, y_hi_q;
  logic [11:0]     x_lo_d, x_hi_d, y_lo_d, y_hi_d;
  int              col_i, row_i;
  logic            in_cell;

  logic [10:0]     hcount_p1_q, vcount_p1_q;
  logic            hsync_p1_q, hblnk_p1_q, vsync_p1_q, vblnk_p1_q;
  logic [11:0]     rgb_p1_q, color_p1_q;
  logic            hl_p1_q;

  assign boundary = vsync_in & ~vsync_q;
  assign sel_ok   = (int'(cell_sel) < NCELL);
  assign en_now   = start_en & ~choice_en & cell_valid & sel_ok;

  // Cell bounds are worked in 12 bits so the far edge of the last column cannot wrap.
  always_comb begin
    col_i  = int'(cell_sel) % COLS;
    row_i  = int'(cell_sel) / COLS;
    x_lo_d = 12'(X0 + col_i * (CELL_W + GAP));
    x_hi_d = x_lo_d + 12'(CELL_W - 1);
    y_lo_d = 12'(Y0 + row_i * (CELL_H + GAP));
    y_hi_d = y_lo_d + 12'(CELL_H - 1);
  end

  always_comb begin
    state_d = state_q;
`ifdef CELL_BLINK_EN
    fcnt_d  = fcnt_q;
`endif
    if (boundary) begin
      if (!en_now) begin
        state_d = IDLE;
`ifdef CELL_BLINK_EN
        fcnt_d  = '0;
`endif
      end else if (state_q == IDLE || cell_sel != sel_q) begin
        // A fresh selection always starts lit with a full ON period.
        state_d = ON;
`ifdef CELL_BLINK_EN
        fcnt_d  = '0;
      end else if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
        state_d = (state_q == ON) ? OFF : ON;
        fcnt_d  = '0;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      sel_q    <= '0;
      player_q <= 1'b0;
      x_lo_q   <= '0;
      x_hi_q   <= '0;
      y_lo_q   <= '0;
      y_hi_q   <= '0;
`ifdef CELL_BLINK_EN
      fcnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_in;
`ifdef CELL_BLINK_EN
      fcnt_q  <= fcnt_d;
`endif
      if (boundary) begin
        sel_q    <= cell_sel;
        player_q <= player;
        x_lo_q   <= x_lo_d[10:0];
        x_hi_q   <= x_hi_d[10:0];
        y_lo_q   <= y_lo_d[10:0];
        y_hi_q   <= y_hi_d[10:0];
      end
    end
  end

  assign in_cell = (hcount_in >= x_lo_q) && (hcount_in <= x_hi_q) &&
                   (vcount_in >= y_lo_q) && (vcount_in <= y_hi_q);

  // Stage 1: register timing and pixel, resolve cell hit against the current frame's snapshot.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_p1_q <= '0;
      vcount_p1_q <= '0;
      hsync_p1_q  <= 1'b0;
      hblnk_p1_q  <= 1'b0;
      vsync_p1_q  <= 1'b0;
      vblnk_p1_q  <= 1'b0;
      rgb_p1_q    <= '0;
      color_p1_q  <= '0;
      hl_p1_q     <= 1'b0;
    end else begin
      hcount_p1_q <= hcount_in;
      vcount_p1_q <= vcount_in;
      hsync_p1_q  <= hsync_in;
      hblnk_p1_q  <= hblnk_in;
      vsync_p1_q  <= vsync_in;
      vblnk_p1_q  <= vblnk_in;
      rgb_p1_q    <= rgb_in;
      color_p1_q  <= player_q ? COLOR_P1 : COLOR_P0;
      hl_p1_q     <= (state_q == ON) && in_cell;
    end
  end

  // Stage 2: colour substitution outside blanking.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_p1_q;
      vcount_out <= vcount_p1_q;
      hsync_out  <= hsync_p1_q;
      hblnk_out  <= hblnk_p1_q;
      vsync_out  <= vsync_p1_q;
      vblnk_out  <= vblnk_p1_q;
      rgb_out    <= (hl_p1_q && !hblnk_p1_q && !vblnk_p1_q) ? color_p1_q : rgb_p1_q;
    end
  end

endmodule

// File: tb/tb_draw_cell_highlight.sv
// Scoreboard bench for draw_cell_highlight: randomized pixels and controls against a frame-level model.
module tb_draw_cell_highlight;
  localparam int COLS = 3, ROWS = 3, X0 = 0, Y0 = 11, CELL_W = 339, CELL_H = 248, GAP = 3, BF = 2;
  localparam logic [11:0] C0 = 12'h00f, C1 = 12'hff0;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        start_en, choice_en, cell_valid, player;
  logic [3:0]  cell_sel;

  draw_cell_highlight #(.BLINK_FRAMES(BF)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en), .cell_valid(cell_valid),
    .cell_sel(cell_sel), .player(player),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t q[$];
  int   checks = 0, errors = 0;

  // Frame-level reference: whether a selection run is active, how many boundaries it has lasted.
  bit m_on, m_player, m_vs_prev;
  int m_age, m_sel;

  function automatic bit model_in_cell(int sel, int h, int v);
    int xl, yl;
    xl = X0 + (sel % COLS) * (CELL_W + GAP);
    yl = Y0 + (sel / COLS) * (CELL_H + GAP);
    return (h >= xl) && (h < xl + CELL_W) && (v >= yl) && (v < yl + CELL_H);
  endfunction

  function automatic bit model_lit();
`ifdef CELL_BLINK_EN
    return m_on && (((m_age / BF) % 2) == 0);
`else
    return m_on;
`endif
  endfunction

  task automatic model_reset();
    m_on = 0; m_player = 0; m_vs_prev = 0; m_age = 0; m_sel = 0;
    q.delete();
  endtask

  // Drive one pixel (called at a negedge), record its expected output, then move to the next negedge.
  task automatic step(input int h, input int v, input bit hs, input bit hb, input bit vs, input bit vb);
    pix_t e;
    bit   en;
    logic [11:0] r;
    r = 12'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb; rgb_in = r;
    e.h = 11'(h); e.v = 11'(v); e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
    e.rgb = (model_lit() && !hb && !vb && model_in_cell(m_sel, int'(11'(h)), int'(11'(v))))
            ? (m_player ? C1 : C0) : r;
    q.push_back(e);
    if (vs && !m_vs_prev) begin
      en = start_en && !choice_en && cell_valid && (int'(cell_sel) < ROWS * COLS);
      if (!en) m_on = 0;
      else if (!m_on || int'(cell_sel) != m_sel) begin m_on = 1; m_age = 0; end
      else m_age++;
      m_sel = int'(cell_sel);
      m_player = player;
    end
    m_vs_prev = vs;
    @(negedge pclk);
  endtask

  task automatic pix(input int h, input int v);
    step(h, v, 0, 0, 0, 0);
  endtask

  task automatic vpulse();
    step(5, 1, 0, 1, 1, 1);
    step(6, 1, 1, 1, 1, 1);
    step(7, 2, 0, 1, 0, 1);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out} != '0) begin
      errors++;
      $display("FAIL %s: outputs h=%0d v=%0d sync/blnk=%b rgb=%h, required all zero", name,
               hcount_out, vcount_out, {hsync_out, hblnk_out, vsync_out, vblnk_out}, rgb_out);
    end
  endtask

  task automatic rand_pix();
    int c, xl, yl, h, v;
    c  = $urandom % (ROWS * COLS);
    xl = X0 + (c % COLS) * (CELL_W + GAP);
    yl = Y0 + (c / COLS) * (CELL_H + GAP);
    case ($urandom % 5)
      0: h = xl - 1;
      1: h = xl;
      2: h = xl + CELL_W - 1;
      3: h = xl + CELL_W;
      default: h = xl + int'($urandom % CELL_W);
    endcase
    case ($urandom % 5)
      0: v = yl - 1;
      1: v = yl;
      2: v = yl + CELL_H - 1;
      3: v = yl + CELL_H;
      default: v = yl + int'($urandom % CELL_H);
    endcase
    step(h, v, bit'($urandom % 2), ($urandom % 10) == 0, 0, ($urandom % 20) == 0);
  endtask

  task automatic rand_ctrl();
    start_en   = ($urandom % 10) != 0;
    choice_en  = ($urandom % 10) == 0;
    cell_valid = ($urandom % 10) != 0;
    if (($urandom % 4) == 0) cell_sel = 4'($urandom % 11);
    if (($urandom % 4) == 0) player = ~player;
  endtask

  // Monitor: outputs appear two clocks after the pixel that produced them.
  initial begin
    pix_t e, a;
    forever begin
      @(posedge pclk); #1;
      if (!rst && q.size() >= 2) begin
        e = q.pop_front();
        a = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL pixel(%0d,%0d): got h=%0d v=%0d hs/hb/vs/vb=%b rgb=%h, required h=%0d v=%0d hs/hb/vs/vb=%b rgb=%h",
                   e.h, e.v, a.h, a.v, {a.hs, a.hb, a.vs, a.vb}, a.rgb,
                   e.h, e.v, {e.hs, e.hb, e.vs, e.vb}, e.rgb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0; vsync_in = 0; vblnk_in = 0;
    rgb_in = '0; start_en = 1; choice_en = 0; cell_valid = 1; cell_sel = 4'd5; player = 0;
    model_reset();
    #1;
    check_zero("reset_t0");
    repeat (3) begin
      @(negedge pclk);
      hcount_in = 11'd700; vcount_in = 11'd300; rgb_in = 12'($urandom);
      check_zero("reset_hold");
    end
    rst = 1'b0;

    // No boundary yet: plain pass-through.
    repeat (4) pix(700, 300);
    vpulse();
    pix(700, 300); pix(684, 300); pix(700, 508); pix(683, 300);
    pix(1022, 509); pix(1023, 300); pix(700, 510); pix(700, 261);

    player = 1; cell_sel = 4'd0;
    pix(700, 300);
    vpulse();
    pix(0, 11); pix(339, 11); pix(338, 258); pix(0, 259); pix(340, 11); pix(342, 11);

    // Blink sequence on cell 4, switching to cell 7 in the third frame.
    cell_sel = 4'd4; player = 0;
    for (int f = 0; f < 8; f++) begin
      vpulse();
      pix(500, 400);
      if (f == 2) cell_sel = 4'd7;
      pix(500, 400); pix(500, 650);
    end

    // Choice menu raised mid-frame, then an out-of-range selection.
    vpulse();
    pix(500, 650);
    choice_en = 1;
    pix(500, 650); pix(500, 650);
    vpulse();
    pix(500, 650);
    choice_en = 0; cell_sel = 4'd9;
    vpulse();
    pix(500, 900); pix(0, 11);
    cell_sel = 4'd1;
    vpulse();
    pix(400, 100);

    // Asynchronous reset in the middle of a line.
    @(posedge pclk); #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("reset_midline");
    repeat (2) begin
      @(negedge pclk);
      check_zero("reset_midline_hold");
    end
    rst = 1'b0;
    pix(400, 100); pix(400, 100); pix(400, 100);
    vpulse();
    pix(400, 100); pix(0, 11);

    for (int f = 0; f < 150; f++) begin
      if (($urandom % 3) == 0) rand_ctrl();
      vpulse();
      for (int p = 0; p < 20 + int'($urandom % 20); p++) begin
        if (($urandom % 25) == 0) rand_ctrl();
        rand_pix();
      end
    end
    pix(0, 0); pix(0, 0); pix(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
